// File: rtl/ula_pkg.sv
// Shared control encodings and FSM state type for the multi-cycle ALU.
package ula_pkg;
  localparam logic [3:0] ULA_AND = 4'b0000;
  localparam logic [3:0] ULA_OR  = 4'b0001;
  localparam logic [3:0] ULA_ADD = 4'b0010;
  localparam logic [3:0] ULA_SRL = 4'b0011;
  localparam logic [3:0] ULA_MUL = 4'b0100;
  localparam logic [3:0] ULA_DIV = 4'b0101;
  localparam logic [3:0] ULA_SUB = 4'b0110;
  localparam logic [3:0] ULA_SLT = 4'b0111;
  localparam logic [3:0] ULA_LUI = 4'b1000;
  localparam logic [3:0] ULA_REM = 4'b1001;
  localparam logic [3:0] ULA_NOT = 4'b1100;
  localparam logic [3:0] ULA_SLL = 4'b1110;

  typedef enum logic [1:0] {IDLE, DIV, DONE} state_t;
endpackage

// File: rtl/ula_divisor.sv
// Iterative datapath: restoring unsigned divider, or shift-add multiplier
// when mul is set at start. One result bit per cycle, WIDTH cycles.
module ula_divisor #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             mul,
  input  logic [WIDTH-1:0] op_a,
  input  logic [WIDTH-1:0] op_b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder
);
  localparam int CW = $clog2(WIDTH);

  logic [WIDTH-1:0] acc, sh, dvs, acc_nxt, sh_nxt;
  logic [WIDTH:0]   shifted, diff;
  logic [CW-1:0]    cnt;
  logic             mode;

  always_comb begin
    shifted = {acc, sh[WIDTH-1]};
    diff    = shifted - {1'b0, dvs};
    sh_nxt  = {sh[WIDTH-2:0], 1'b0};
    if (mode) begin
      acc_nxt = {acc[WIDTH-2:0], 1'b0} + (sh[WIDTH-1] ? dvs : '0);
    end else if (!diff[WIDTH]) begin
      acc_nxt   = diff[WIDTH-1:0];
      sh_nxt[0] = 1'b1;
    end else begin
      acc_nxt = shifted[WIDTH-1:0];
    end
  end

  // Outputs expose the post-step values so the caller can latch the final
  // result on the same edge that performs the last iteration.
  assign done      = busy && (cnt == '0);
  assign quotient  = mode ? acc_nxt : sh_nxt;
  assign remainder = acc_nxt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy <= 1'b0;
      mode <= 1'b0;
      cnt  <= '0;
      acc  <= '0;
      sh   <= '0;
      dvs  <= '0;
    end else if (start) begin
      busy <= 1'b1;
      mode <= mul;
      cnt  <= CW'(WIDTH - 1);
      acc  <= '0;
      sh   <= op_a;
      dvs  <= op_b;
    end else if (busy) begin
      acc <= acc_nxt;
      sh  <= sh_nxt;
      cnt <= cnt - 1'b1;
      if (cnt == '0) busy <= 1'b0;
    end
  end
endmodule

// File: rtl/ula_multiciclo.sv
// Multi-cycle ALU with valid/ready handshake and iterative div/rem.
// Define ULA_MUL_ITER_EN to run mul on the iterative datapath instead.
module ula_multiciclo
  import ula_pkg::*;
#(
  parameter int WIDTH     = 32,
  parameter int LUI_SHIFT = 18
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       ctl,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             zero,
  output logic             div_by_zero
);
  localparam int SH_W = $clog2(WIDTH);

  state_t           state;
  logic [3:0]       op_ctl;
  logic [WIDTH-1:0] alu_res, fin_res, dv_quo, dv_rem;
  logic             b_zero, is_divrem, is_iter, is_mul, start, dv_busy, dv_done;

  assign b_zero    = (b == '0);
  assign is_divrem = (ctl == ULA_DIV) || (ctl == ULA_REM);
`ifdef ULA_MUL_ITER_EN
  assign is_mul  = (ctl == ULA_MUL);
  assign is_iter = (is_divrem && !b_zero) || is_mul;
`else
  assign is_mul  = 1'b0;
  assign is_iter = is_divrem && !b_zero;
`endif
  assign start   = (state == IDLE) && in_valid && is_iter;
  assign fin_res = (op_ctl == ULA_REM) ? dv_rem : dv_quo;

  ula_divisor #(.WIDTH(WIDTH)) u_div (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .mul       (is_mul),
    .op_a      (a),
    .op_b      (b),
    .busy      (dv_busy),
    .done      (dv_done),
    .quotient  (dv_quo),
    .remainder (dv_rem)
  );

  // div/rem entries here only cover b == 0; nonzero divisors go iterative.
  always_comb begin
    alu_res = '0;
    case (ctl)
      ULA_AND: alu_res = a & b;
      ULA_OR:  alu_res = a | b;
      ULA_ADD: alu_res = a + b;
      ULA_SRL: alu_res = a >> b[SH_W-1:0];
`ifdef ULA_MUL_ITER_EN
      ULA_MUL: alu_res = '0;
`else
      ULA_MUL: alu_res = a * b;
`endif
      ULA_DIV: alu_res = '1;
      ULA_SUB: alu_res = a - b;
      ULA_SLT: alu_res = WIDTH'(a < b);
      ULA_LUI: alu_res = b << LUI_SHIFT;
      ULA_REM: alu_res = a;
      ULA_NOT: alu_res = ~a;
      ULA_SLL: alu_res = a << b[SH_W-1:0];
      default: alu_res = '0;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      in_ready    <= 1'b1;
      out_valid   <= 1'b0;
      result      <= '0;
      zero        <= 1'b1;
      div_by_zero <= 1'b0;
      op_ctl      <= '0;
    end else begin
      case (state)
        IDLE: if (in_valid) begin
          op_ctl   <= ctl;
          in_ready <= 1'b0;
          if (is_iter) begin
            state       <= DIV;
            div_by_zero <= 1'b0;
          end else begin
            state       <= DONE;
            out_valid   <= 1'b1;
            result      <= alu_res;
            zero        <= (alu_res == '0);
            div_by_zero <= is_divrem && b_zero;
          end
        end
        DIV: if (dv_done || !dv_busy) begin
          state     <= DONE;
          out_valid <= 1'b1;
          result    <= fin_res;
          zero      <= (fin_res == '0);
        end
        DONE: if (out_ready) begin
          state     <= IDLE;
          out_valid <= 1'b0;
          in_ready  <= 1'b1;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_ula_multiciclo.sv
// Self-checking bench for ula_multiciclo: directed cases plus random traffic
// compared cycle by cycle against a behavioural model.
module tb_ula_multiciclo;
  localparam int W = 32;
  localparam logic [3:0] C_AND = 4'h0, C_OR = 4'h1, C_ADD = 4'h2, C_SRL = 4'h3,
                         C_MUL = 4'h4, C_DIV = 4'h5, C_SUB = 4'h6, C_SLT = 4'h7,
                         C_LUI = 4'h8, C_REM = 4'h9, C_NOT = 4'hC, C_SLL = 4'hE;
`ifdef ULA_MUL_ITER_EN
  localparam int MUL_LAT = W + 1;
`else
  localparam int MUL_LAT = 1;
`endif

  logic clk = 1'b0;
  logic rst_n, in_valid, in_ready, out_valid, out_ready, zero, div_by_zero;
  logic [3:0]   ctl;
  logic [W-1:0] a, b, result;
  int checks = 0, failures = 0, cyc = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  ula_multiciclo #(.WIDTH(W), .LUI_SHIFT(18)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .ctl(ctl), .a(a), .b(b), .out_valid(out_valid), .out_ready(out_ready),
    .result(result), .zero(zero), .div_by_zero(div_by_zero)
  );

  task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h t=%0t", name, act, exp, $time);
    end
  endtask

  function automatic void model(input logic [3:0] c, input logic [W-1:0] x, input logic [W-1:0] y,
                                output logic [W-1:0] r, output bit dz, output int lat);
    logic [2*W-1:0] p;
    logic [4:0] s;
    s = y[4:0];
    dz = 1'b0;
    lat = 1;
    case (c)
      C_AND: r = x & y;
      C_OR:  r = x | y;
      C_ADD: r = x + y;
      C_SRL: r = x >> s;
      C_MUL: begin p = {{W{1'b0}}, x} * {{W{1'b0}}, y}; r = p[W-1:0]; lat = MUL_LAT; end
      C_DIV: if (y == 0) begin r = '1; dz = 1'b1; end else begin r = x / y; lat = W + 1; end
      C_SUB: r = x - y;
      C_SLT: r = (x < y) ? 1 : 0;
      C_LUI: r = y << 18;
      C_REM: if (y == 0) begin r = x; dz = 1'b1; end else begin r = x % y; lat = W + 1; end
      C_NOT: r = ~x;
      C_SLL: r = x << s;
      default: r = '0;
    endcase
  endfunction

  // Compare process: model of outstanding request, checked every cycle.
  bit m_busy = 0, m_out = 0, m_dz = 0;
  int m_cnt = 0;
  logic [W-1:0] m_res = '0;
  always @(negedge clk) begin
    if (!rst_n) begin
      m_busy = 0; m_out = 0; m_cnt = 0;
      chk("rst_in_ready", in_ready, 1);
      chk("rst_out_valid", out_valid, 0);
      chk("rst_result", result, 0);
      chk("rst_zero", zero, 1);
      chk("rst_dbz", div_by_zero, 0);
    end else begin
      if (m_busy && !m_out) begin
        m_cnt--;
        if (m_cnt == 0) m_out = 1;
      end
      chk("in_ready", in_ready, !m_busy);
      chk("out_valid", out_valid, m_out);
      if (m_out) begin
        chk("result", result, m_res);
        chk("zero", zero, (m_res == 0));
        chk("div_by_zero", div_by_zero, m_dz);
      end
      if (!m_busy && in_valid) begin
        model(ctl, a, b, m_res, m_dz, m_cnt);
        m_busy = 1;
      end else if (m_out && out_ready) begin
        m_busy = 0; m_out = 0;
      end
    end
  end

  task automatic wait_idle(input string nm);
    int n = 0;
    while (!in_ready && n < 200) begin @(posedge clk); #2; n++; end
    if (!in_ready) chk({nm, "_idle_timeout"}, 0, 1);
  endtask

  task automatic run(input logic [3:0] c, input logic [W-1:0] x, input logic [W-1:0] y,
                     input logic [W-1:0] er, input bit ed, input int el, input string nm);
    int t0, n;
    wait_idle(nm);
    in_valid = 1; ctl = c; a = x; b = y; t0 = cyc;
    @(posedge clk); #2;
    in_valid = 0; ctl = 4'($urandom); a = $urandom; b = $urandom;
    n = 0;
    while (!out_valid && n < 200) begin @(posedge clk); #2; n++; end
    chk({nm, "_latency"}, cyc - t0, el);
    chk({nm, "_result"}, result, er);
    chk({nm, "_dbz"}, div_by_zero, ed);
    out_ready = 1;
    @(posedge clk); #2;
    out_ready = 0;
  endtask

  initial begin
    logic [3:0] codes [16];
    for (int i = 0; i < 16; i++) codes[i] = 4'(i);
    rst_n = 1; in_valid = 0; out_ready = 0; ctl = '0; a = '0; b = '0;
    #1 rst_n = 0;
    repeat (3) @(posedge clk);
    #2 rst_n = 1;

    run(C_ADD, 32'hFFFF_FFFF, 32'd1, 32'h0, 0, 1, "add_wrap");
    run(C_SUB, 32'd3, 32'd5, 32'hFFFF_FFFE, 0, 1, "sub_wrap");
    run(C_SLT, 32'h8000_0000, 32'd1, 32'h0, 0, 1, "slt_unsigned");
    run(C_DIV, 32'd100, 32'd7, 32'd14, 0, 33, "div");
    run(C_REM, 32'd100, 32'd7, 32'd2, 0, 33, "rem");
    run(C_DIV, 32'd5, 32'd0, 32'hFFFF_FFFF, 1, 1, "div_by0");
    run(C_AND, 32'hF0, 32'h3C, 32'h30, 0, 1, "and_clears_dbz");
    run(C_REM, 32'd77, 32'd0, 32'd77, 1, 1, "rem_by0");
    run(C_MUL, 32'd12345, 32'd678, 32'd8369910, 0, MUL_LAT, "mul");
    run(C_LUI, 32'h0000_ABCD, 32'h0, 32'h0, 0, 1, "lui_b0");
    run(C_LUI, 32'h0, 32'h0000_3FFF, 32'hFFFC_0000, 0, 1, "lui");
    run(C_SRL, 32'h8000_0000, 32'h0000_0FFF, 32'h1, 0, 1, "srl_31");
    run(C_SLL, 32'h1, 32'h0000_0024, 32'h10, 0, 1, "sll_mask");
    run(C_DIV, 32'hFFFF_FFFF, 32'd1, 32'hFFFF_FFFF, 0, 33, "div_max");
    run(4'hF, 32'h1234, 32'h5678, 32'h0, 0, 1, "undef_code");

    // Backpressure: result must hold and new requests must be ignored.
    wait_idle("bp");
    in_valid = 1; ctl = C_OR; a = 32'h1234; b = 32'h5678;
    @(posedge clk); #2;
    ctl = C_ADD; a = 32'h1; b = 32'h1;
    repeat (10) begin
      chk("bp_in_ready", in_ready, 0);
      chk("bp_result", result, 32'h567C);
      @(posedge clk); #2;
    end
    in_valid = 0; out_ready = 1;
    @(posedge clk); #2;
    out_ready = 0;
    chk("bp_release_in_ready", in_ready, 1);
    chk("bp_release_out_valid", out_valid, 0);

    // Reset in the middle of a division.
    wait_idle("rst_mid");
    in_valid = 1; ctl = C_DIV; a = 32'd1000; b = 32'd3;
    @(posedge clk); #2;
    in_valid = 0;
    repeat (9) @(posedge clk);
    #2 rst_n = 0;
    #1;
    chk("rst_mid_out_valid", out_valid, 0);
    chk("rst_mid_in_ready", in_ready, 1);
    @(posedge clk); #2 rst_n = 1;
    run(C_DIV, 32'd9, 32'd3, 32'd3, 0, 33, "div_after_rst");

    // Random traffic; the compare process checks every cycle.
    repeat (2000) begin
      in_valid = 1'($urandom_range(0, 1));
      ctl = codes[$urandom_range(0, 15)];
      case ($urandom_range(0, 3))
        0: b = '0;
        1: b = $urandom_range(1, 40);
        default: b = $urandom;
      endcase
      a = ($urandom_range(0, 3) == 0) ? W'($urandom_range(0, 300)) : W'($urandom);
      out_ready = ($urandom_range(0, 2) != 0);
      @(posedge clk); #2;
    end
    in_valid = 0; out_ready = 1;
    repeat (40) @(posedge clk);
    #2;
    chk("drain_in_ready", in_ready, 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
